entrada_cedulas: RTL and testbench



---
 rtl/entrada_cedulas.sv | 182 ++++++++++++++++++
 tb/tb_entrada_cedulas.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/entrada_cedulas.sv
// Banknote entry stage: debounced insert/cancel buttons, credit accumulation and
// display-control generation (latched note code, V_sense, sinal_cancel, digit scan).
module entrada_cedulas #(
  parameter int DIV_SCAN        = 1000,
  parameter int DEBOUNCE_CICLOS = 500000,
  parameter int EXIBE_CICLOS    = 50000000,
  parameter int CANCEL_CICLOS   = 5000000,
  parameter int LIMITE          = 200
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [2:0] chaves_cedulas,
  input  logic       botao_inserir,
  input  logic       botao_cancelar,
  output logic [2:0] cedula_reg,
  output logic       V_sense,
  output logic       sinal_cancel,
  output logic [2:0] select,
  output logic [7:0] credito,
  output logic       rejeitado
);

  localparam int PW   = $clog2(DIV_SCAN) + 1;
  localparam int DW   = $clog2(DEBOUNCE_CICLOS) + 1;
  localparam int TMAX = (EXIBE_CICLOS > CANCEL_CICLOS) ? EXIBE_CICLOS : CANCEL_CICLOS;
  localparam int TW   = $clog2(TMAX) + 1;

  localparam logic [PW-1:0] PRESC_FIM  = PW'(DIV_SCAN - 1);
  localparam logic [DW-1:0] DEB_FIM    = DW'(DEBOUNCE_CICLOS - 1);
  localparam logic [DW-1:0] DEB_SAT    = DW'(DEBOUNCE_CICLOS);
  localparam logic [TW-1:0] EXIBE_FIM  = TW'(EXIBE_CICLOS - 1);
  localparam logic [TW-1:0] CANCEL_FIM = TW'(CANCEL_CICLOS - 1);
  localparam logic [8:0]    LIM9       = 9'(LIMITE);

  typedef enum logic [1:0] {OCIOSO, EXIBE, CANCELA} estado_t;

  estado_t             estado_q, estado_d;
  logic [PW-1:0]       presc_q, presc_d;
  logic [2:0]          select_q, select_d;
  logic [1:0]          sync1_q, sync1_d, sync2_q, sync2_d;
  logic [1:0][DW-1:0]  deb_cnt_q, deb_cnt_d;
  logic [1:0]          pulso;
  logic [TW-1:0]       timer_q, timer_d;
  logic [2:0]          cedula_q, cedula_d;
  logic [7:0]          credito_q, credito_d;
  logic                v_sense_q, v_sense_d;
  logic                cancel_q, cancel_d;
  logic                rej_q, rej_d;
  logic [7:0]          valor;
  logic [8:0]          soma;

  function automatic logic [7:0] valor_cedula(input logic [2:0] c);
    case (c)
      3'b001:  return 8'd1;
      3'b010:  return 8'd2;
      3'b011:  return 8'd5;
      3'b100:  return 8'd10;
      3'b101:  return 8'd20;
      3'b110:  return 8'd50;
      3'b111:  return 8'd100;
      default: return 8'd0;
    endcase
  endfunction

  always_comb begin
    presc_d  = presc_q + PW'(1);
    select_d = select_q;
    if (presc_q == PRESC_FIM) begin
      presc_d  = '0;
      select_d = (select_q == 3'd6) ? 3'd0 : select_q + 3'd1;
    end
  end

  // Index 0 is insert, index 1 is cancel; the count saturates so a held button pulses once.
  always_comb begin
    sync1_d   = {botao_cancelar, botao_inserir};
    sync2_d   = sync1_q;
    deb_cnt_d = deb_cnt_q;
    pulso     = 2'b00;
    for (int i = 0; i < 2; i++) begin
      if (sync2_q[i]) begin
        deb_cnt_d[i] = '0;
      end else if (deb_cnt_q[i] != DEB_SAT) begin
        deb_cnt_d[i] = deb_cnt_q[i] + DW'(1);
        pulso[i]     = (deb_cnt_q[i] == DEB_FIM);
      end
    end
  end

  assign valor = valor_cedula(chaves_cedulas);
  assign soma  = {1'b0, credito_q} + {1'b0, valor};

  always_comb begin
    estado_d  = estado_q;
    timer_d   = '0;
    cedula_d  = cedula_q;
    credito_d = credito_q;
    v_sense_d = v_sense_q;
    cancel_d  = cancel_q;
    rej_d     = 1'b0;
    case (estado_q)
      OCIOSO: begin
        if (pulso[1]) begin
          estado_d  = CANCELA;
          credito_d = '0;
          cedula_d  = '0;
          cancel_d  = 1'b1;
          v_sense_d = 1'b1;
        end else if (pulso[0] && (chaves_cedulas != 3'b000)) begin
          if (soma <= LIM9) begin
            estado_d  = EXIBE;
            cedula_d  = chaves_cedulas;
            credito_d = soma[7:0];
            v_sense_d = 1'b0;
          end else begin
            rej_d = 1'b1;
          end
        end
      end
      EXIBE: begin
        timer_d = timer_q + TW'(1);
        if (pulso[1]) begin
          estado_d  = CANCELA;
          timer_d   = '0;
          credito_d = '0;
          cedula_d  = '0;
          cancel_d  = 1'b1;
          v_sense_d = 1'b1;
        end else if (timer_q == EXIBE_FIM) begin
          estado_d  = OCIOSO;
          v_sense_d = 1'b1;
        end
      end
      CANCELA: begin
        timer_d = timer_q + TW'(1);
        if (timer_q == CANCEL_FIM) begin
          estado_d = OCIOSO;
          cancel_d = 1'b0;
        end
      end
      default: estado_d = OCIOSO;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      estado_q  <= OCIOSO;
      presc_q   <= '0;
      select_q  <= '0;
      sync1_q   <= 2'b11;
      sync2_q   <= 2'b11;
      deb_cnt_q <= '0;
      timer_q   <= '0;
      cedula_q  <= '0;
      credito_q <= '0;
      v_sense_q <= 1'b1;
      cancel_q  <= 1'b0;
      rej_q     <= 1'b0;
    end else begin
      estado_q  <= estado_d;
      presc_q   <= presc_d;
      select_q  <= select_d;
      sync1_q   <= sync1_d;
      sync2_q   <= sync2_d;
      deb_cnt_q <= deb_cnt_d;
      timer_q   <= timer_d;
      cedula_q  <= cedula_d;
      credito_q <= credito_d;
      v_sense_q <= v_sense_d;
      cancel_q  <= cancel_d;
      rej_q     <= rej_d;
    end
  end

  assign cedula_reg   = cedula_q;
  assign V_sense      = v_sense_q;
  assign sinal_cancel = cancel_q;
  assign select       = select_q;
  assign credito      = credito_q;
  assign rejeitado    = rej_q;

endmodule

// File: tb/tb_entrada_cedulas.sv
// Bench for entrada_cedulas: directed scenarios plus random button activity, all
// outputs compared every cycle against a behavioural credit/display model.
module tb_entrada_cedulas;

  localparam int DEB = 3;
  localparam int EXB = 10;
  localparam int CAN = 5;
  localparam int LIM = 200;

  logic       clk = 1'b0;
  logic       reset;
  logic [2:0] chaves_cedulas;
  logic       botao_inserir;
  logic       botao_cancelar;
  logic [2:0] cedula_reg;
  logic       V_sense;
  logic       sinal_cancel;
  logic [2:0] select;
  logic [7:0] credito;
  logic       rejeitado;

  entrada_cedulas #(
    .DIV_SCAN(4), .DEBOUNCE_CICLOS(DEB), .EXIBE_CICLOS(EXB),
    .CANCEL_CICLOS(CAN), .LIMITE(LIM)
  ) dut (
    .clk(clk), .reset(reset), .chaves_cedulas(chaves_cedulas),
    .botao_inserir(botao_inserir), .botao_cancelar(botao_cancelar),
    .cedula_reg(cedula_reg), .V_sense(V_sense), .sinal_cancel(sinal_cancel),
    .select(select), .credito(credito), .rejeitado(rejeitado)
  );

  always #5 clk = ~clk;

  int n_assert = 0;
  int n_fail   = 0;
  int vlow_cnt, rej_cnt, canc_cnt;

  // Model: edges since reset, raw button history, run length of low level, and a
  // mode with cycles remaining (0 idle, 1 showing a note, 2 cancelling).
  int          m_cyc, m_runi, m_runc, m_mode, m_left, m_cred;
  logic        m_i1, m_i2, m_c1, m_c2, m_rej;
  logic [2:0]  m_ced;
  int          vals [8] = '{0, 1, 2, 5, 10, 20, 50, 100};

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_cyc = 0; m_runi = 0; m_runc = 0; m_mode = 0; m_left = 0; m_cred = 0;
    m_i1 = 1'b1; m_i2 = 1'b1; m_c1 = 1'b1; m_c2 = 1'b1; m_rej = 1'b0; m_ced = 3'd0;
  endtask

  task automatic enter_cancel();
    m_mode = 2; m_left = CAN; m_cred = 0; m_ced = 3'd0;
  endtask

  task automatic model_update();
    logic pi, pc;
    m_cyc++;
    m_runi = m_i2 ? 0 : m_runi + 1;
    m_runc = m_c2 ? 0 : m_runc + 1;
    pi = (m_runi == DEB);
    pc = (m_runc == DEB);
    m_i2 = m_i1; m_i1 = botao_inserir;
    m_c2 = m_c1; m_c1 = botao_cancelar;
    m_rej = 1'b0;
    case (m_mode)
      0: if (pc) enter_cancel();
         else if (pi && chaves_cedulas != 3'd0) begin
           if (m_cred + vals[chaves_cedulas] <= LIM) begin
             m_cred = m_cred + vals[chaves_cedulas];
             m_ced = chaves_cedulas; m_mode = 1; m_left = EXB;
           end else m_rej = 1'b1;
         end
      1: if (pc) enter_cancel();
         else begin m_left--; if (m_left == 0) m_mode = 0; end
      default: begin m_left--; if (m_left == 0) m_mode = 0; end
    endcase
  endtask

  task automatic check_outputs();
    chk("select",       select,       (m_cyc / 4) % 7);
    chk("V_sense",      V_sense,      (m_mode != 1));
    chk("sinal_cancel", sinal_cancel, (m_mode == 2));
    chk("credito",      credito,      m_cred);
    chk("cedula_reg",   cedula_reg,   m_ced);
    chk("rejeitado",    rejeitado,    m_rej);
    vlow_cnt += (V_sense === 1'b0);
    rej_cnt  += (rejeitado === 1'b1);
    canc_cnt += (sinal_cancel === 1'b1);
  endtask

  task automatic step(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      model_update();
      @(negedge clk);
      check_outputs();
    end
  endtask

  task automatic press(input logic [2:0] code, input int hold, input int after);
    chaves_cedulas = code;
    botao_inserir = 1'b0;
    step(hold);
    botao_inserir = 1'b1;
    step(after);
  endtask

  initial begin
    reset = 1'b1; botao_inserir = 1'b1; botao_cancelar = 1'b1; chaves_cedulas = 3'd0;
    vlow_cnt = 0; rej_cnt = 0; canc_cnt = 0;
    model_reset();
    #12;
    @(negedge clk);
    reset = 1'b0;
    check_outputs();

    // free-running scan, idle outputs
    step(32);

    // bouncing insert never reaches the stability count
    chaves_cedulas = 3'b101;
    for (int r = 0; r < 5; r++) begin
      botao_inserir = 1'b0; step(2);
      botao_inserir = 1'b1; step(2);
    end
    step(4);
    chk("bounce_credito", credito, 0);

    // long press: single acceptance, 10 cycles of display
    vlow_cnt = 0;
    press(3'b100, 20, 15);
    chk("t2_credito", credito, 10);
    chk("t2_cedula", cedula_reg, 3'b100);
    chk("t2_vlow_cycles", vlow_cnt, EXB);

    // cancel during display
    canc_cnt = 0;
    press(3'b010, 8, 0);
    chk("t5_in_exibe", V_sense, 0);
    botao_cancelar = 1'b0; step(6);
    botao_cancelar = 1'b1; step(12);
    chk("t5_cancel_cycles", canc_cnt, CAN);
    chk("t5_credito", credito, 0);
    chk("t5_cedula", cedula_reg, 0);

    // 100 + 100 reaches the limit, +1 is refused
    press(3'b111, 6, 14);
    chk("t4_first", credito, 100);
    press(3'b111, 6, 14);
    chk("t4_second", credito, 200);
    rej_cnt = 0; vlow_cnt = 0;
    press(3'b001, 6, 8);
    chk("t4_rej_pulses", rej_cnt, 1);
    chk("t4_credito", credito, 200);
    chk("t4_vlow", vlow_cnt, 0);

    // simultaneous insert and cancel: cancel wins
    canc_cnt = 0; vlow_cnt = 0;
    chaves_cedulas = 3'b011;
    botao_inserir = 1'b0; botao_cancelar = 1'b0; step(6);
    botao_inserir = 1'b1; botao_cancelar = 1'b1; step(10);
    chk("t5b_cancel_cycles", canc_cnt, CAN);
    chk("t5b_credito", credito, 0);
    chk("t5b_vlow", vlow_cnt, 0);

    // asynchronous reset during display
    press(3'b110, 6, 3);
    chk("t6_in_exibe", V_sense, 0);
    #2 reset = 1'b1;
    #1;
    chk("t6_rst_cedula", cedula_reg, 0);
    chk("t6_rst_vsense", V_sense, 1);
    chk("t6_rst_cancel", sinal_cancel, 0);
    chk("t6_rst_credito", credito, 0);
    chk("t6_rst_rej", rejeitado, 0);
    model_reset();
    @(negedge clk);
    @(negedge clk);
    chk("t6_rst_select", select, 0);
    reset = 1'b0;
    step(30);

    // random button activity
    for (int k = 0; k < 40; k++) begin
      int act;
      act = $urandom_range(0, 9);
      chaves_cedulas = 3'($urandom_range(0, 7));
      botao_inserir  = (act < 8) ? 1'b0 : 1'b1;
      botao_cancelar = (act >= 7) ? 1'b0 : 1'b1;
      step($urandom_range(1, 8));
      botao_inserir = 1'b1; botao_cancelar = 1'b1;
      step($urandom_range(1, 16));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
